// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: word-wide data memory port between the load/store controller and memory.
interface lsu_mem_ctrl_if;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  func3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    modport master (output we, addr, func3, wdata, input rdata, ready);
    modport slave  (input we, addr, func3, wdata, output rdata, ready);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage RV32I load/store initiator; sub-word stores via read-modify-write,
// loads via lane extraction and sign/zero extension, with a ready timeout.
module lsu_mem_ctrl #(
    parameter int READY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_req_func3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy,
    lsu_mem_ctrl_if.master mem
);
    localparam int CW = $clog2(READY_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE_R, WAIT_R, ISSUE_W, WAIT_W, RESP} state_t;
    state_t      r_state, w_next;
    logic        r_we, w_we, r_resp_valid, r_err, w_err, r_rmw, w_rmw;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_rdata, w_rdata;
    logic [CW-1:0] r_cnt, w_cnt, w_inc;
    logic [1:0]  r_a, w_a;
    logic [2:0]  r_f3, w_f3;
    logic [15:0] r_wd, w_wd;
    logic [31:0] w_sh, w_load, w_mask, w_ins, w_merge;
    logic [15:0] w_h;
    logic [7:0]  w_b;
    logic        w_bad;
    assign w_sh    = mem.rdata >> {r_a, 3'b000};
    assign w_b     = w_sh[7:0];
    assign w_h     = r_a[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    assign w_load  = r_f3 == 3'd0 ? {{24{w_b[7]}}, w_b} :
                     r_f3 == 3'd1 ? {{16{w_h[15]}}, w_h} :
                     r_f3 == 3'd4 ? {24'd0, w_b} :
                     r_f3 == 3'd5 ? {16'd0, w_h} : mem.rdata;
    assign w_mask  = r_f3[0] ? (32'h0000_FFFF << {r_a[1], 4'b0000}) : (32'h0000_00FF << {r_a, 3'b000});
    assign w_ins   = r_f3[0] ? {2{r_wd}} : {4{r_wd[7:0]}};
    assign w_merge = (mem.rdata & ~w_mask) | (w_ins & w_mask);
    assign w_inc   = r_cnt + CW'(1);
    // Stores only exist as B/H/W; misalignment is judged on the byte address before it is word-aligned
    assign w_bad   = (i_req_func3 == 3'd3) || (i_req_func3[2:1] == 2'b11) || (i_req_store && i_req_func3[2]) ||
                     (i_req_func3[1:0] == 2'd1 && i_req_addr[0]) || (i_req_func3 == 3'd2 && |i_req_addr[1:0]);
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rdata = r_rdata;
        w_err   = r_err;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_f3    = r_f3;
        w_wd    = r_wd;
        w_rmw   = r_rmw;
        unique case (r_state)
            IDLE: if (i_req_valid) begin
                w_a   = i_req_addr[1:0];
                w_f3  = i_req_func3;
                w_wd  = i_req_wdata[15:0];
                w_rmw = i_req_store && i_req_func3 != 3'd2;
                if (w_bad) begin
                    w_next  = RESP;
                    w_rdata = '0;
                    w_err   = 1'b1;
                end else begin
                    w_addr = {i_req_addr[31:2], 2'b00};
                    w_cnt  = '0;
                    if (i_req_store && i_req_func3 == 3'd2) begin
                        w_next  = ISSUE_W;
                        w_we    = 1'b1;
                        w_wdata = i_req_wdata;
                    end else begin
                        w_next = ISSUE_R;
                    end
                end
            end
            ISSUE_R: w_next = WAIT_R;
            ISSUE_W: w_next = WAIT_W;
            WAIT_R: if (mem.ready) begin
                if (r_rmw) begin
                    w_next  = ISSUE_W;
                    w_we    = 1'b1;
                    w_wdata = w_merge;
                    w_cnt   = '0;
                end else begin
                    w_next  = RESP;
                    w_rdata = w_load;
                    w_err   = 1'b0;
                end
            end else if (w_inc == CW'(READY_TIMEOUT)) begin
                w_next  = RESP;
                w_rdata = '0;
                w_err   = 1'b1;
            end else begin
                w_cnt = w_inc;
            end
            WAIT_W: if (mem.ready) begin
                w_next  = RESP;
                w_rdata = '0;
                w_err   = 1'b0;
            end else if (w_inc == CW'(READY_TIMEOUT)) begin
                w_next  = RESP;
                w_rdata = '0;
                w_err   = 1'b1;
            end else begin
                w_cnt = w_inc;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_f3         <= '0;
            r_wd         <= '0;
            r_rmw        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_resp_valid <= w_next == RESP;
            r_rdata      <= w_rdata;
            r_err        <= w_err;
            r_cnt        <= w_cnt;
            r_a          <= w_a;
            r_f3         <= w_f3;
            r_wd         <= w_wd;
            r_rmw        <= w_rmw;
        end
    end
    assign o_req_ready  = r_state == IDLE;
    assign o_busy       = r_state != IDLE;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
    assign mem.we       = r_we;
    assign mem.addr     = r_addr;
    assign mem.func3    = 3'b010;
    assign mem.wdata    = r_wdata;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed load/store sequence against a word memory model with a
// scoreboard of expected result, error flag and response latency.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    lsu_mem_ctrl_if m();
    lsu_mem_ctrl #(.READY_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_store(req_store), .i_req_func3(req_func3), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
        .o_resp_err(resp_err), .o_busy(busy), .mem(m)
    );
    always #5 clk = ~clk;

    typedef struct {logic [31:0] rd; logic err; int lat;} exp_t;
    exp_t        exp_q[$];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] mem_arr [0:63];
    logic        ready_en = 1'b1, pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          n_we = 0, n_resp = 0;
    logic [31:0] we_addr = '0, we_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_idx] <= pl_val;
        else if (m.we) mem_arr[m.addr[7:2]] <= m.wdata;
        m.rdata <= mem_arr[m.addr[7:2]];
        m.ready <= ready_en;
        if (m.we) begin
            n_we    <= n_we + 1;
            we_addr <= m.addr;
            we_data <= m.wdata;
        end
        if (resp_valid) n_resp <= n_resp + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic op(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
        int n;
        exp_t e;
        exp_q.push_back('{er, ee, lat});
        drive(st, f3, a, wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_busy"}, busy, 1'b1);
        end while (!resp_valid && n < 100);
        e = exp_q.pop_front();
        check({tag, "_valid"}, resp_valid, 1'b1);
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_rdata"}, resp_rdata, e.rd);
        check({tag, "_err"}, resp_err, e.err);
        @(negedge clk);
        check({tag, "_pulse"}, resp_valid, 1'b0);
        check({tag, "_idle"}, req_ready, 1'b1);
    endtask

    initial begin
        int we0, resp0;
        logic [31:0] a0;
        for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
        preload(6'd4, 32'h8081_7F01);
        preload(6'd8, 32'h1122_3344);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", resp_err, 1'b0);
        check("rst_we", m.we, 1'b0);
        check("rst_addr", m.addr, 32'h0);
        check("rst_wdata", m.wdata, 32'h0);
        check("func3", m.func3, 32'd2);
        @(negedge clk) reset = 1'b0;

        op("lb11", 0, 3'd0, 32'h11, 0, 32'h0000_007F, 0, 3);
        op("lb13", 0, 3'd0, 32'h13, 0, 32'hFFFF_FF80, 0, 3);
        op("lbu13", 0, 3'd4, 32'h13, 0, 32'h0000_0080, 0, 3);
        op("lh12", 0, 3'd1, 32'h12, 0, 32'hFFFF_8081, 0, 3);
        op("lhu12", 0, 3'd5, 32'h12, 0, 32'h0000_8081, 0, 3);
        op("lh10", 0, 3'd1, 32'h10, 0, 32'h0000_7F01, 0, 3);
        op("lw10", 0, 3'd2, 32'h10, 0, 32'h8081_7F01, 0, 3);

        we0 = n_we;
        op("sb22", 1, 3'd0, 32'h22, 32'h0000_00AB, 32'h0, 0, 5);
        check("sb22_we_cnt", n_we - we0, 1);
        check("sb22_we_addr", we_addr, 32'h20);
        check("sb22_we_data", we_data, 32'h11AB_3344);
        check("sb22_mem", mem_arr[8], 32'h11AB_3344);
        op("sh22", 1, 3'd1, 32'h22, 32'h0000_CAFE, 32'h0, 0, 5);
        check("sh22_mem", mem_arr[8], 32'hCAFE_3344);
        op("sh20", 1, 3'd1, 32'h20, 32'h1234_5678, 32'h0, 0, 5);
        check("sh20_mem", mem_arr[8], 32'hCAFE_5678);

        we0 = n_we;
        op("sw40", 1, 3'd2, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 3);
        check("sw40_we_cnt", n_we - we0, 1);
        check("sw40_mem", mem_arr[16], 32'hDEAD_BEEF);
        op("lw40", 0, 3'd2, 32'h40, 0, 32'hDEAD_BEEF, 0, 3);

        we0 = n_we;
        a0 = m.addr;
        op("lh41", 0, 3'd1, 32'h41, 0, 32'h0, 1, 1);
        op("sw42", 1, 3'd2, 32'h42, 32'h5555_5555, 32'h0, 1, 1);
        op("ld_f3_3", 0, 3'd3, 32'h10, 0, 32'h0, 1, 1);
        check("err_no_we", n_we - we0, 0);
        check("err_addr_kept", m.addr, a0);
        check("err_mem40", mem_arr[16], 32'hDEAD_BEEF);

        ready_en = 1'b0;
        op("timeout", 0, 3'd2, 32'h10, 0, 32'h0, 1, 18);
        ready_en = 1'b1;
        op("lw_after_to", 0, 3'd2, 32'h10, 0, 32'h8081_7F01, 0, 3);

        we0 = n_we;
        resp0 = n_resp;
        drive(1, 3'd1, 32'h22, 32'h0000_5555);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("rst_mid_we", m.we, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_addr", m.addr, 32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_no_we", n_we - we0, 0);
        check("rst_mid_no_resp", n_resp - resp0, 0);
        check("rst_mid_mem", mem_arr[8], 32'hCAFE_5678);
        op("lw_after_rst", 0, 3'd2, 32'h20, 0, 32'hCAFE_5678, 0, 3);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
